float_min2_finder: RTL

Min-sum check-node reduction stage for the LDPC decoder. It sits directly downstream of the float adder that forms variable-to-check messages. Each frame it consumes DEG IEEE-754 single-precision messages and reports:
- the smallest magnitude (min1) and its index;
- the second-smallest magnitude (min2);
- the XOR of all input signs.

The check-to-variable message generator consumes these results.

---
 rtl/float_min2_finder.sv | 113 +++++++++++
 1 files changed

// File: rtl/float_min2_finder.sv
// Min-sum check-node reduction: finds min1/min2 magnitudes, min1 index and sign XOR over DEG float32 messages.
// Optional: define FLOAT_MIN2_SAT_EN to clamp Inf/NaN magnitudes to the largest finite value before comparing.
module float_min2_finder #(
  parameter int DEG  = 6,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [30:0]     out_min1,
  output logic [30:0]     out_min2,
  output logic [IDXW-1:0] out_idx,
  output logic            out_sign
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [30:0]     MAG_INIT = 31'h7FFF_FFFF;
  localparam logic [30:0]     MAG_SAT  = 31'h7F7F_FFFF;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEG - 1);

  state_t          state, state_nxt;
  logic [IDXW-1:0] cnt, idx, idx_nxt;
  logic [30:0]     min1, min2, min1_nxt, min2_nxt, mag;
  logic            sgn, sgn_nxt;
  logic            accept, last, release_out;

  // in_ready/out_valid decode straight from the state flop, so they stay registered.
  assign in_ready    = (state == ACC);
  assign out_valid   = (state == HOLD);
  assign accept      = in_valid && in_ready;
  assign last        = accept && (cnt == LAST_IDX);
  assign release_out = out_valid && out_ready;

`ifdef FLOAT_MIN2_SAT_EN
  assign mag = (in_data[30:23] == 8'hFF) ? MAG_SAT : in_data[30:0];
`else
  assign mag = in_data[30:0];
`endif

  // Strict less-than: on ties the earlier index keeps min1 and the later value becomes min2.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    min1_nxt = min1;
    min2_nxt = min2;
    idx_nxt  = idx;
    sgn_nxt  = sgn ^ in_data[31];
    if (mag < min1) begin
      min2_nxt = min1;
      min1_nxt = mag;
      idx_nxt  = cnt;
    end else if (mag < min2) begin
      min2_nxt = mag;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (last)      state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst) state <= ACC;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      idx  <= '0;
      min1 <= MAG_INIT;
      min2 <= MAG_INIT;
      sgn  <= 1'b0;
    end else if (release_out) begin
      cnt  <= '0;
      idx  <= '0;
      min1 <= MAG_INIT;
      min2 <= MAG_INIT;
      sgn  <= 1'b0;
    end else if (accept) begin
      cnt  <= last ? '0 : cnt + 1'b1;
      idx  <= idx_nxt;
      min1 <= min1_nxt;
      min2 <= min2_nxt;
      sgn  <= sgn_nxt;
    end
  end

  // Result registers capture the frame including the final input and hold until the next frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_min1 <= '0;
      out_min2 <= '0;
      out_idx  <= '0;
      out_sign <= 1'b0;
    end else if (last) begin
      out_min1 <= min1_nxt;
      out_min2 <= min2_nxt;
      out_idx  <= idx_nxt;
      out_sign <= sgn_nxt;
    end
  end

endmodule
